// File: rtl/bin_sched_ctrl.sv
// ---------------------------------------------------------------------------
// bin_sched_ctrl
// Top-level sequencer for the bin manager. For each bin it performs four
// steps in order: load the bin into the SAT engine, run the engine, write the
// bin back, then pick the next bin. On SAT it moves forward one bin. On a
// conflict it jumps to the backtrack bin. It reports sticky SAT/UNSAT results
// and counts the loads it issues.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             one-cycle pulse, begin solving from bin 0 (idle only)
//   num_bins_i          total bins, sampled with start_i
//   start_load_o        one-cycle pulse to load_bin
//   request_bin_num_o   bin to load/update (cur_bin register)
//   done_load_i         load_bin completion pulse
//   start_core_o        one-cycle pulse to the SAT engine
//   done_core_i         engine completion pulse, qualifies core_* below
//   core_sat_i          bin satisfied
//   core_bkt_bin_i      backtrack target bin on conflict
//   core_bkt_lvl_i      backtrack level on conflict (0 = root conflict)
//   start_update_o      one-cycle pulse to the write-back block
//   done_update_i       write-back completion pulse
//   busy_o              solve in progress
//   global_sat_o        sticky SAT result
//   global_unsat_o      sticky UNSAT result
//   switch_cnt_o        loads issued since start_i (wraps)
// ---------------------------------------------------------------------------
module bin_sched_ctrl #(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_CNT    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_BIN_ID-1:0] num_bins_i,
    output logic                    start_load_o,
    output logic [WIDTH_BIN_ID-1:0] request_bin_num_o,
    input  logic                    done_load_i,
    output logic                    start_core_o,
    input  logic                    done_core_i,
    input  logic                    core_sat_i,
    input  logic [WIDTH_BIN_ID-1:0] core_bkt_bin_i,
    input  logic [WIDTH_LVL-1:0]    core_bkt_lvl_i,
    output logic                    start_update_o,
    input  logic                    done_update_i,
    output logic                    busy_o,
    output logic                    global_sat_o,
    output logic                    global_unsat_o,
    output logic [WIDTH_CNT-1:0]    switch_cnt_o
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_LOAD,
        RUN,
        WAIT_CORE,
        UPDATE,
        WAIT_UPD,
        NEXT,
        FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH_BIN_ID-1:0] cur_bin_q, cur_bin_d;
    logic [WIDTH_BIN_ID-1:0] num_bins_q, num_bins_d;
    logic [WIDTH_CNT-1:0]    cnt_d;
    logic                    sat_d, unsat_d;

    // Engine result captured on done_core_i, consumed in NEXT.
    logic                    cap_sat_q, cap_sat_d;
    logic [WIDTH_BIN_ID-1:0] cap_bin_q, cap_bin_d;
    logic [WIDTH_LVL-1:0]    cap_lvl_q, cap_lvl_d;

    logic                    start_load_d, start_core_d, start_update_d, busy_d;

    // One extra bit so that cur_bin+1 cannot wrap before it is compared
    // with num_bins.
    logic [WIDTH_BIN_ID:0]   cur_bin_inc;
    logic                    last_bin;

    assign cur_bin_inc = {1'b0, cur_bin_q} + {{WIDTH_BIN_ID{1'b0}}, 1'b1};
    assign last_bin    = (cur_bin_inc == {1'b0, num_bins_q});

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_bin_d  = cur_bin_q;
        num_bins_d = num_bins_q;
        cnt_d      = switch_cnt_o;
        sat_d      = global_sat_o;
        unsat_d    = global_unsat_o;
        cap_sat_d  = cap_sat_q;
        cap_bin_d  = cap_bin_q;
        cap_lvl_d  = cap_lvl_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    num_bins_d = num_bins_i;
                    cur_bin_d  = '0;
                    cnt_d      = '0;
                    sat_d      = 1'b0;
                    unsat_d    = 1'b0;
                    // An empty problem is trivially SAT; FINISH raises the
                    // flag, so it appears two cycles after start_i.
                    state_d    = (num_bins_i == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                cnt_d   = switch_cnt_o + WIDTH_CNT'(1);
                state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                if (done_load_i) state_d = RUN;
            end
            RUN: begin
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (done_core_i) begin
                    cap_sat_d = core_sat_i;
                    cap_bin_d = core_bkt_bin_i;
                    cap_lvl_d = core_bkt_lvl_i;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                state_d = WAIT_UPD;
            end
            WAIT_UPD: begin
                if (done_update_i) state_d = NEXT;
            end
            NEXT: begin
                if (cap_sat_q) begin
                    if (last_bin) begin
                        sat_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        cur_bin_d = cur_bin_inc[WIDTH_BIN_ID-1:0];
                        state_d   = LOAD;
                    end
                end else if (cap_lvl_q == '0 || cap_bin_q >= num_bins_q) begin
                    // A root conflict, or a backtrack target outside the
                    // problem, ends the solve as UNSAT.
                    unsat_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    cur_bin_d = cap_bin_q;
                    state_d   = LOAD;
                end
            end
            FINISH: begin
                // Only the empty-problem path arrives here with num_bins == 0.
                if (num_bins_q == '0) sat_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pulses are registered copies of the state being entered, so each
        // pulse lasts exactly one cycle.
        start_load_d   = (state_d == LOAD);
        start_core_d   = (state_d == RUN);
        start_update_d = (state_d == UPDATE);
        busy_d         = (state_d != IDLE && state_d != FINISH) ||
                         (state_d == FINISH && num_bins_d == '0);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_bin_q      <= '0;
            num_bins_q     <= '0;
            cap_sat_q      <= 1'b0;
            cap_bin_q      <= '0;
            cap_lvl_q      <= '0;
            switch_cnt_o   <= '0;
            global_sat_o   <= 1'b0;
            global_unsat_o <= 1'b0;
            start_load_o   <= 1'b0;
            start_core_o   <= 1'b0;
            start_update_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_bin_q      <= cur_bin_d;
            num_bins_q     <= num_bins_d;
            cap_sat_q      <= cap_sat_d;
            cap_bin_q      <= cap_bin_d;
            cap_lvl_q      <= cap_lvl_d;
            switch_cnt_o   <= cnt_d;
            global_sat_o   <= sat_d;
            global_unsat_o <= unsat_d;
            start_load_o   <= start_load_d;
            start_core_o   <= start_core_d;
            start_update_o <= start_update_d;
            busy_o         <= busy_d;
        end
    end

    assign request_bin_num_o = cur_bin_q;

endmodule
